strobe_timestamper: RTL and testbench

Acquisition front end that timestamps rising edges on the four strobe and four delta inputs and emits one 47-bit record per event cycle. It sits directly upstream of the record FIFO.

- Its `record_rdy` / `record[46:0]` outputs drive the FIFO write side.
- The FIFO/top level appends bit 47, the lost flag.
- It runs entirely in the acquisition clock domain.
- It also emits rollover marker records so the host can reconstruct absolute time from the truncated timestamp.

---
 rtl/strobe_timestamper.sv | 73 +++++++
 tb/tb_strobe_timestamper.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_timestamper.sv
// Timestamps rising edges on four strobe and four delta pins and emits one
// 47-bit record per event cycle, plus wrap markers on timestamp rollover.
module strobe_timestamper #(
    parameter int unsigned TS_WIDTH = 36
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  strobe_in,
    input  logic [3:0]  delta_in,
    input  logic [3:0]  strobe_mask,
    input  logic [3:0]  delta_mask,
    input  logic        running,
    output logic        record_rdy,
    output logic [46:0] record,
    output logic [31:0] record_count
);
    localparam int unsigned CH_W       = 8;
    localparam int unsigned TS_FIELD_W = 36;
    localparam int unsigned CNT_W      = 32;

    logic [CH_W-1:0]     s1;
    logic [CH_W-1:0]     s2;
    logic [CH_W-1:0]     prev;
    logic [CH_W-1:0]     hit_c;
    logic [TS_WIDTH-1:0] ts;
    logic                wrap_c;
    logic                event_c;

    // Channel order {delta, strobe} matches the record hit field layout.
    assign hit_c   = s2 & ~prev & {delta_mask, strobe_mask};
    assign wrap_c  = running & (ts == {TS_WIDTH{1'b1}});
    assign event_c = running & ((|hit_c) | wrap_c);

    // Synchronizer and edge history run independently of running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= {delta_in, strobe_in};
            s2   <= s1;
            prev <= s2;
        end
    end

    // Free-running timestamp while acquiring, parked at zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
        end else if (!running) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    // Record capture uses the pre-increment timestamp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            record_rdy   <= 1'b0;
            record       <= '0;
            record_count <= '0;
        end else begin
            record_rdy <= event_c;
            if (event_c) begin
                record       <= {2'b00, wrap_c, hit_c, TS_FIELD_W'(ts)};
                record_count <= record_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_strobe_timestamper.sv
// Self-checking bench for strobe_timestamper: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_strobe_timestamper;
    localparam int unsigned TSW = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  strobe_in = '0;
    logic [3:0]  delta_in = '0;
    logic [3:0]  strobe_mask = 4'hF;
    logic [3:0]  delta_mask = 4'hF;
    logic        running = 1'b0;
    logic        record_rdy;
    logic [46:0] record;
    logic [31:0] record_count;

    int checks = 0;
    int errors = 0;

    strobe_timestamper #(.TS_WIDTH(TSW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .strobe_in   (strobe_in),
        .delta_in    (delta_in),
        .strobe_mask (strobe_mask),
        .delta_mask  (delta_mask),
        .running     (running),
        .record_rdy  (record_rdy),
        .record      (record),
        .record_count(record_count)
    );

    always #5 clk = ~clk;

    // Reference model: a pin level counts two edges after it is sampled; a
    // hit is a masked 0->1 change of that delayed level. The timestamp is the
    // number of consecutive running edges, modulo 2^TSW.
    logic [7:0]  samp[$];
    logic [7:0]  m_pins, m_lvl, m_old, m_hits, m_ts;
    logic        m_wrap;
    int unsigned run_len = 0;
    logic        m_rdy = 1'b0;
    logic [46:0] m_rec = '0;
    logic [31:0] m_cnt = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                samp.delete();
                run_len = 0;
                m_rdy   = 1'b0;
                m_rec   = '0;
                m_cnt   = '0;
            end else begin
                m_pins = {delta_in, strobe_in};
                samp.push_back(m_pins);
                if (samp.size() > 4) void'(samp.pop_front());
                m_lvl = 8'h00;
                m_old = 8'h00;
                if (samp.size() >= 3) m_lvl = samp[samp.size()-3];
                if (samp.size() >= 4) m_old = samp[samp.size()-4];
                m_hits = m_lvl & ~m_old & {delta_mask, strobe_mask};
                if (running) begin
                    m_ts   = 8'(run_len % 256);
                    m_wrap = (m_ts == 8'hFF);
                    m_rdy  = (m_hits != 8'h00) || m_wrap;
                    if (m_rdy) begin
                        m_rec = {2'b00, m_wrap, m_hits, 28'd0, m_ts};
                        m_cnt = m_cnt + 32'd1;
                    end
                    run_len++;
                end else begin
                    m_rdy   = 1'b0;
                    run_len = 0;
                end
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        reset_n     = 1'b0;
        running     = 1'b0;
        strobe_in   = '0;
        delta_in    = '0;
        strobe_mask = 4'hF;
        delta_mask  = 4'hF;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (record_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: got %b want 0", record_rdy);
        end
        checks++;
        if (record !== 47'd0) begin
            errors++; $display("FAIL reset_record: got %h want 0", record);
        end
        checks++;
        if (record_count !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", record_count);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({record_rdy, record_count} !== 33'd0) begin
            errors++; $display("FAIL idle_after_reset: got rdy=%b cnt=%0d want 0/0", record_rdy, record_count);
        end
    endtask

    task automatic test_single_strobe;
        do_reset();
        @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 9) strobe_in[2] = 1'b1;
            checks++;
            if (record_rdy !== 1'(i == 12)) begin
                errors++; $display("FAIL single_rdy cyc %0d: got %b want %b", i, record_rdy, (i == 12));
            end
            if (i == 12) begin
                checks++;
                if (record[44:36] !== 9'b0_0000_0100 || record[35:0] !== 36'd12 || record_count !== 32'd1) begin
                    errors++; $display("FAIL single_rec: got hits/wrap=%b ts=%0d cnt=%0d want 000000100 12 1", record[44:36], record[35:0], record_count);
                end
            end
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL single_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
        end
        strobe_in[2] = 1'b0;
    endtask

    task automatic test_coincident;
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                strobe_in[0] = 1'b1;
                delta_in[3]  = 1'b1;
            end
            if (record_rdy === 1'b1) begin
                pulses++;
                checks++;
                if (record[44:36] !== 9'b0_1000_0001) begin
                    errors++; $display("FAIL coincident_bits: got %b want 010000001", record[44:36]);
                end
            end
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL coincident_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL coincident_count: got %0d records want 1", pulses);
        end
        strobe_in[0] = 1'b0;
        delta_in[3]  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rollover;
        do_reset();
        @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < 780; i++) begin
            @(negedge clk);
            if (i == 764) strobe_in[1] = 1'b1;
            if (i == 770) strobe_in[1] = 1'b0;
            checks++;
            if (record_rdy !== 1'(i == 255 || i == 511 || i == 767)) begin
                errors++; $display("FAIL rollover_rdy cyc %0d: got %b", i, record_rdy);
            end
            if (i == 255 || i == 511 || i == 767) begin
                checks++;
                if (record[44:36] !== ((i == 767) ? 9'b1_0000_0010 : 9'b1_0000_0000) || record[35:0] !== 36'hFF) begin
                    errors++; $display("FAIL rollover_rec cyc %0d: got bits=%b ts=%h", i, record[44:36], record[35:0]);
                end
            end
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL rollover_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
        end
    endtask

    task automatic test_mask_enable;
        do_reset();
        strobe_mask = 4'b1110;
        @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            case (i)
                2:  strobe_in[0] = 1'b1;
                5:  strobe_in[0] = 1'b0;
                10: strobe_in[0] = 1'b1;
                15: strobe_mask  = 4'hF;
                20: running      = 1'b0;
                22: strobe_in[1] = 1'b1;
                26: running      = 1'b1;
                30: strobe_in[1] = 1'b0;
                33: strobe_in[1] = 1'b1;
                default: ;
            endcase
            checks++;
            if (record_rdy !== 1'(i == 36)) begin
                errors++; $display("FAIL mask_rdy cyc %0d: got %b want %b", i, record_rdy, (i == 36));
            end
            if (i == 36) begin
                checks++;
                if (record[44:36] !== 9'b0_0000_0010 || record[35:0] !== 36'd9) begin
                    errors++; $display("FAIL mask_rec: got bits=%b ts=%0d want 000000010 9", record[44:36], record[35:0]);
                end
            end
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL mask_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
        end
        strobe_in = '0;
    endtask

    task automatic test_held_b2b;
        logic [35:0] first_ts = '0;
        do_reset();
        @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 1)  strobe_in[1] = 1'b1;
            if (i == 51) strobe_in[1] = 1'b0;
            if (i == 60) strobe_in[0] = 1'b1;
            if (i == 61) strobe_in[1] = 1'b1;
            checks++;
            if (record_rdy !== 1'(i == 4 || i == 63 || i == 64)) begin
                errors++; $display("FAIL held_rdy cyc %0d: got %b", i, record_rdy);
            end
            if (i == 63) begin
                first_ts = record[35:0];
                checks++;
                if (record[39:36] !== 4'b0001) begin
                    errors++; $display("FAIL b2b_first: got hits=%b want 0001", record[39:36]);
                end
            end
            if (i == 64) begin
                checks++;
                if (record[39:36] !== 4'b0010 || record[35:0] !== first_ts + 36'd1) begin
                    errors++; $display("FAIL b2b_second: got hits=%b ts=%0d want 0010 %0d", record[39:36], record[35:0], first_ts + 36'd1);
                end
            end
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL held_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
        end
        strobe_in = '0;
    endtask

    task automatic test_random;
        running = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL random_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
            if ($urandom_range(0, 3) == 0) strobe_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) delta_in  = 4'($urandom);
            if ($urandom_range(0, 99) == 0) running = ~running;
            if ($urandom_range(0, 199) == 0) strobe_mask = 4'($urandom);
            if ($urandom_range(0, 199) == 0) delta_mask  = 4'($urandom);
        end
    endtask

    task automatic test_async_reset;
        bit seen = 1'b0;
        do_reset();
        @(negedge clk);
        running      = 1'b1;
        strobe_in[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (record_rdy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL async_wait: got no record_rdy within 10 cycles want one");
        end
        reset_n = 1'b0;
        running = 1'b0;
        #1;
        checks++;
        if ({record_rdy, record_count, record} !== 80'd0) begin
            errors++; $display("FAIL async_clear: got %b/%0d/%h want all zero", record_rdy, record_count, record);
        end
        @(negedge clk);
        strobe_in = '0;
        reset_n   = 1'b1;
        @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) strobe_in[0] = 1'b1;
            checks++;
            if (record_rdy !== 1'(i == 3)) begin
                errors++; $display("FAIL async_restart_rdy cyc %0d: got %b", i, record_rdy);
            end
            if (i == 3) begin
                checks++;
                if (record[35:0] !== 36'd3 || record_count !== 32'd1 || record[39:36] !== 4'b0001) begin
                    errors++; $display("FAIL async_restart_rec: got ts=%0d cnt=%0d hits=%b want 3 1 0001", record[35:0], record_count, record[39:36]);
                end
            end
            checks++;
            if ({record_rdy, record_count, record} !== {m_rdy, m_cnt, m_rec}) begin
                errors++; $display("FAIL async_model cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, record_rdy, record_count, record, m_rdy, m_cnt, m_rec);
            end
        end
        strobe_in = '0;
    endtask

    initial begin
        test_reset();
        test_single_strobe();
        test_coincident();
        test_rollover();
        test_mask_enable();
        test_held_b2b();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
